// File: rtl/gf163_pkg.sv
// gf163_pkg: shared GF(2^163) constants and helpers for the NIST B-163/K-163
// field, f(z) = z^163 + z^7 + z^6 + z^3 + 1, polynomial basis.
//   M          : field degree
//   POLY_LO    : f(z) - z^163, folded back in on every reduction
//   op_sel_e   : operand select for the Itoh-Tsujii chain multiplies
//   state_e    : divider FSM encoding
//   chain_*    : Itoh-Tsujii addition-chain ROM (squarings, operand) per step
//   gf163_xtime: multiply by z, reduced
//   gf163_sqr  : combinational squaring, reduced
package gf163_pkg;

    localparam int M = 163;
    localparam logic [M-1:0] POLY_LO = M'(8'hC9);  // z^7 + z^6 + z^3 + 1
    localparam logic [3:0] LAST_STEP = 4'd9;

    typedef enum logic [1:0] {OP_S, OP_A, OP_X} op_sel_e;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SQR, ST_MUL, ST_DONE} state_e;

    // Chain builds y^(2^k-1) for k = 2,4,5,10,20,40,80,81,162, then a final
    // squaring times x gives x * y^(2^163-2) = x / y.
    function automatic logic [7:0] chain_sq_cnt(input logic [3:0] step);
        case (step)
            4'd0:    return 8'd1;
            4'd1:    return 8'd2;
            4'd2:    return 8'd1;
            4'd3:    return 8'd5;
            4'd4:    return 8'd10;
            4'd5:    return 8'd20;
            4'd6:    return 8'd40;
            4'd7:    return 8'd1;
            4'd8:    return 8'd81;
            default: return 8'd1;
        endcase
    endfunction

    function automatic op_sel_e chain_op(input logic [3:0] step);
        case (step)
            4'd2, 4'd7: return OP_A;
            4'd9:       return OP_X;
            default:    return OP_S;
        endcase
    endfunction

    function automatic logic [M-1:0] gf163_xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LO : '0);
    endfunction

    // Squaring spreads bits to even positions, then folds the top M-1 bits down.
    // Folding high-to-low lets a fold that lands above M-1 get folded again.
    function automatic logic [M-1:0] gf163_sqr(input logic [M-1:0] a);
        logic [2*M-2:0] w;
        w = '0;
        for (int i = 0; i < M; i++) w[2*i] = a[i];
        for (int i = 2*M-2; i >= M; i--) begin
            if (w[i]) begin
                w[i-M]   ^= 1'b1;
                w[i-M+3] ^= 1'b1;
                w[i-M+6] ^= 1'b1;
                w[i-M+7] ^= 1'b1;
            end
        end
        return w[M-1:0];
    endfunction

endpackage

// File: rtl/gf163_div_unit_if.sv
// gf163_div_unit_if: operand and result ready/valid channels of the divider.
//   in_valid/in_ready/x_in/y_in         : operand channel (numerator, denominator)
//   out_valid/out_ready/quo_out/div_by_zero : result channel
// slave = the divider, master = the requester.
interface gf163_div_unit_if;
    import gf163_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] x_in;
    logic [M-1:0] y_in;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] quo_out;
    logic         div_by_zero;

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, quo_out, div_by_zero
    );

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, quo_out, div_by_zero
    );

endinterface

// File: rtl/gf163_digit_mul.sv
// gf163_digit_mul: MSB-first digit-serial GF(2^163) multiplier with
// interleaved reduction, DIGIT bits of b per cycle.
//   clk, rst : clock, async active-high reset
//   start    : load a/b; the first digit is consumed on the same edge
//   a, b     : operands
//   done     : one-cycle pulse, P = ceil(163/DIGIT) cycles after start
//   p        : a*b mod f, valid with done and held until the next start
module gf163_digit_mul
    import gf163_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         done,
    output logic [M-1:0] p
);

    localparam int P  = (M + DIGIT - 1) / DIGIT;
    localparam int BW = P * DIGIT;

    logic [M-1:0]  a_q, a_d, acc_q, acc_d;
    logic [BW-1:0] b_q, b_d, b_pad;
    logic [7:0]    rem_q, rem_d;
    logic          busy_q, busy_d, done_q, done_d;

    // Horner step: acc*z^DIGIT + a*d, reducing after every single-bit shift.
    function automatic logic [M-1:0] mac_digit(input logic [M-1:0] acc,
                                               input logic [M-1:0] av,
                                               input logic [DIGIT-1:0] d);
        logic [M-1:0] r;
        r = acc;
        for (int i = DIGIT-1; i >= 0; i--) r = gf163_xtime(r) ^ (d[i] ? av : '0);
        return r;
    endfunction

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        done_d = 1'b0;
        b_pad  = BW'(b);
        if (start) begin
            a_d    = a;
            acc_d  = mac_digit('0, a, b_pad[BW-1 -: DIGIT]);
            b_d    = b_pad << DIGIT;
            rem_d  = 8'(P-1);
            busy_d = (P > 1);
            done_d = (P == 1);
        end else if (busy_q) begin
            acc_d = mac_digit(acc_q, a_q, b_q[BW-1 -: DIGIT]);
            b_d   = b_q << DIGIT;
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/gf163_div_unit.sv
// gf163_div_unit: constant-time GF(2^163) divider, quo = x * y^-1 mod f,
// via a fixed Itoh-Tsujii chain (162 squarings, 10 multiplies).
//   clk, rst : clock, async active-high reset
//   bus      : slave side of gf163_div_unit_if (operand and result channels)
// Latency from accepting edge to out_valid: 1 + 162 + 10*ceil(163/DIGIT).
module gf163_div_unit #(
    parameter int DIGIT = 4,
    parameter int M     = 163
) (
    input  logic               clk,
    input  logic               rst,
    gf163_div_unit_if.slave    bus
);
    import gf163_pkg::*;

    state_e       state_q, state_d;
    logic [M-1:0] a_q, a_d, x_q, x_d, t_q, t_d, s_q, s_d, quo_q, quo_d;
    logic [3:0]   step_q, step_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         dbz_q, dbz_d, ov_q, ov_d;

    logic [M-1:0] t_sqr, mul_b, mul_p;
    logic         mul_start, mul_done;
    logic [3:0]   step_nx;

    gf163_digit_mul #(.DIGIT(DIGIT)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (t_sqr),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        x_d       = x_q;
        t_d       = t_q;
        s_d       = s_q;
        quo_d     = quo_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        ov_d      = ov_q;
        mul_start = 1'b0;
        t_sqr     = gf163_sqr(t_q);
        step_nx   = step_q + 4'd1;
        case (chain_op(step_q))
            OP_A:    mul_b = a_q;
            OP_X:    mul_b = x_q;
            default: mul_b = s_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.y_in;
                    x_d     = bus.x_in;
                    t_d     = bus.y_in;
                    dbz_d   = (bus.y_in == '0);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                step_d  = 4'd0;
                cnt_d   = chain_sq_cnt(4'd0);
                s_d     = t_q;
                state_d = ST_SQR;
            end
            ST_SQR: begin
                t_d   = t_sqr;
                cnt_d = cnt_q - 8'd1;
                // The multiplier takes the final square combinationally, so
                // the squaring edge doubles as the first multiply edge.
                if (cnt_q == 8'd1) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    t_d = mul_p;
                    if (step_q != LAST_STEP) begin
                        step_d = step_nx;
                        cnt_d  = chain_sq_cnt(step_nx);
                        if (chain_op(step_nx) == OP_S) s_d = mul_p;
                        state_d = ST_SQR;
                    end else begin
                        quo_d   = mul_p;
                        ov_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            x_q     <= '0;
            t_q     <= '0;
            s_q     <= '0;
            quo_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            t_q     <= t_d;
            s_q     <= s_d;
            quo_q   <= quo_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = ov_q;
    assign bus.quo_out     = quo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf163_div_unit.sv
// tb_gf163_div_unit: table-driven bench for gf163_div_unit (DIGIT=4).
// Directed rows carry hand-computed quotients; random rows are checked by
// the defining property quo*y mod f == x. Hand sequences cover output stall
// with ignored in_valid, and reset in the middle of an operation.
module tb_gf163_div_unit;

    localparam int DIGIT   = 4;
    localparam int EXP_LAT = 1 + 162 + 10 * ((163 + DIGIT - 1) / DIGIT);
    localparam logic [162:0] INV_Z = 163'h4_00000000_00000000_00000000_00000000_00000064;
    localparam logic [162:0] K1    = 163'h5_a5a5a5a5_0123_4567_89ab_cdef_dead_beef_0f0f_1234;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf163_div_unit_if bus_if ();

    gf163_div_unit #(.DIGIT(DIGIT), .M(163)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [162:0] x;
        logic [162:0] y;
        logic [162:0] q;
        logic         dbz;
        bit           prop;  // check q*y == x instead of a fixed q
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [162:0] act, input logic [162:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = {r[161:0], 1'b0} ^ (r[162] ? 163'hC9 : 163'h0);
            if (b[i]) r ^= a;
        end
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[162:0];
    endfunction

    task automatic start_div(input logic [162:0] x, input logic [162:0] y);
        @(negedge clk);
        bus_if.x_in     = x;
        bus_if.y_in     = y;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus_if.out_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [162:0] r, q0;
        bit stable;

        bus_if.in_valid  = 1'b0;
        bus_if.x_in      = '0;
        bus_if.y_in      = '0;
        bus_if.out_ready = 1'b1;

        vecs[0] = '{163'h1, 163'h1, 163'h1, 1'b0, 1'b0};
        vecs[1] = '{163'h1, 163'h2, INV_Z, 1'b0, 1'b0};
        vecs[2] = '{163'h4, 163'h2, 163'h2, 1'b0, 1'b0};
        vecs[3] = '{163'h2, 163'h1, 163'h2, 1'b0, 1'b0};
        vecs[4] = '{163'h0, K1, 163'h0, 1'b0, 1'b0};
        vecs[5] = '{K1, 163'h0, 163'h0, 1'b1, 1'b0};
        vecs[6] = '{K1, K1, 163'h1, 1'b0, 1'b0};
        vecs[7] = '{K1, 163'h1, K1, 1'b0, 1'b0};
        vecs[8] = '{163'h1, INV_Z, 163'h2, 1'b0, 1'b0};
        for (int i = 9; i < NV; i++) begin
            r = rand163();
            if (r == '0) r = 163'h3;
            vecs[i] = '{rand163(), r, 163'h0, 1'b0, 1'b1};
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 163'(bus_if.in_ready), 163'h1);
        check("rst_out_valid", 163'(bus_if.out_valid), 163'h0);
        check("rst_quo", bus_if.quo_out, 163'h0);
        check("rst_dbz", 163'(bus_if.div_by_zero), 163'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_div(vecs[i].x, vecs[i].y);
            wait_result(lat);
            check($sformatf("lat[%0d]", i), 163'(lat), 163'(EXP_LAT));
            if (vecs[i].prop) check($sformatf("q*y[%0d]", i), gf_mul(bus_if.quo_out, vecs[i].y), vecs[i].x);
            else              check($sformatf("quo[%0d]", i), bus_if.quo_out, vecs[i].q);
            check($sformatf("dbz[%0d]", i), 163'(bus_if.div_by_zero), 163'(vecs[i].dbz));
            @(posedge clk);
            #1;
            check($sformatf("hs[%0d]", i), {161'h0, bus_if.in_ready, bus_if.out_valid}, 163'h2);
        end

        // Output stall: result held, new operands ignored.
        bus_if.out_ready = 1'b0;
        start_div(K1, 163'h2);
        wait_result(lat);
        check("stall_lat", 163'(lat), 163'(EXP_LAT));
        q0 = bus_if.quo_out;
        check("stall_q*y", gf_mul(q0, 163'h2), K1);
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b1;
            bus_if.x_in     = 163'h1;
            bus_if.y_in     = 163'h1;
            @(posedge clk);
            #1;
            if (bus_if.quo_out !== q0 || bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("stall_stable", 163'(stable), 163'h1);
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", {161'h0, bus_if.in_ready, bus_if.out_valid}, 163'h2);
        @(posedge clk);
        #1;
        check("stall_idle", {161'h0, bus_if.in_ready, bus_if.out_valid}, 163'h2);
        check("stall_quo_kept", bus_if.quo_out, q0);

        // Reset in the middle of a division.
        start_div(163'h1, 163'h2);
        repeat (200) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ov", 163'(bus_if.out_valid), 163'h0);
        check("mid_rst_quo", bus_if.quo_out, 163'h0);
        check("mid_rst_rdy", 163'(bus_if.in_ready), 163'h1);
        start_div(163'h4, 163'h2);
        wait_result(lat);
        check("post_rst_lat", 163'(lat), 163'(EXP_LAT));
        check("post_rst_quo", bus_if.quo_out, 163'h2);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
